// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forwarding controller for a 5-stage RISC-V pipeline
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   id_rs1/id_rs2, *_used          source registers read by the ID instruction
//   ex_rs1/ex_rs2                  source registers of the EX instruction (forwarding)
//   ex_wR, ex_rf_we, ex_is_load    EX destination, write enable, load flag (load-use)
//   ex_branch_taken                branch/jump resolved taken in EX
//   mem_wR/mem_rf_we               EX/MEM destination and write enable
//   wb_wR/wb_rf_we                 MEM/WB destination and write enable
//   mem_req/mem_ack                data-memory handshake from the MEM stage
//   *_stall, *_flush               pipeline register hold / bubble controls
//   fwd_a_sel/fwd_b_sel            0 RF, 1 EX/MEM, 2 MEM/WB
//   mem_timeout                    sticky: a memory wait reached TIMEOUT cycles
//   stall_cnt/flush_cnt            saturating stall-cycle and branch-flush counters
module pipe_hazard_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_wR,
  input  logic             ex_rf_we,
  input  logic             ex_is_load,
  input  logic             ex_branch_taken,
  input  logic [4:0]       mem_wR,
  input  logic             mem_rf_we,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic [4:0]       wb_wR,
  input  logic             wb_rf_we,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             mem_wb_flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [15:0]      WAIT_LIM = 16'(TIMEOUT);
  state_t      state, state_nxt;
  logic [15:0] wait_cnt;
  logic        mem_busy, load_use, br_flush, lu_stall;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RUN;
    else     state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (state == RUN && mem_req && !mem_ack) state_nxt = MEM_WAIT;
    if (state == MEM_WAIT && mem_ack)        state_nxt = RUN;
  end
  always_comb begin
    mem_busy     = (state == RUN) ? (mem_req && !mem_ack) : !mem_ack;
    load_use     = ex_is_load && ex_rf_we && ex_wR != 5'd0 &&
                   ((id_rs1_used && id_rs1 == ex_wR) || (id_rs2_used && id_rs2 == ex_wR));
    // A frozen EX re-presents its branch, so a taken branch waits out mem_busy.
    br_flush     = !mem_busy && ex_branch_taken;
    lu_stall     = !mem_busy && !ex_branch_taken && load_use;
    pc_stall     = mem_busy || lu_stall;
    if_id_stall  = mem_busy || lu_stall;
    id_ex_stall  = mem_busy;
    ex_mem_stall = mem_busy;
    mem_wb_flush = mem_busy;
    if_id_flush  = br_flush;
    id_ex_flush  = br_flush || lu_stall;
  end
  always_comb begin
    fwd_a_sel = (mem_rf_we && mem_wR != 5'd0 && mem_wR == ex_rs1) ? 2'd1 :
                (wb_rf_we  && wb_wR  != 5'd0 && wb_wR  == ex_rs1) ? 2'd2 : 2'd0;
    fwd_b_sel = (mem_rf_we && mem_wR != 5'd0 && mem_wR == ex_rs2) ? 2'd1 :
                (wb_rf_we  && wb_wR  != 5'd0 && wb_wR  == ex_rs2) ? 2'd2 : 2'd0;
  end
  // Held at zero in RUN so every wait starts counting from zero; it stops at
  // the limit, and the flag sets on the edge closing the TIMEOUT-th wait cycle.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (state == RUN) begin
      wait_cnt    <= '0;
    end else begin
      if (wait_cnt < WAIT_LIM)          wait_cnt    <= wait_cnt + 16'd1;
      if (wait_cnt >= WAIT_LIM - 16'd1) mem_timeout <= 1'b1;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_stall && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
      if (br_flush && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + 1'b1;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/forwarding controller for the 5-stage RISC-V pipeline.
- Drives the hold and bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Selects forwarding sources for the EX-stage operands.
- Sequences multi-cycle data-memory accesses with a wait FSM, and keeps stall/flush performance counters plus a sticky memory-timeout flag.

Parameters:
CNT_W, 16, width of the saturating performance counters
TIMEOUT, 255, max MEM_WAIT cycles before mem_timeout sets (1..2^16-1)

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-high reset
id_rs1  in  5  rs1 index of instruction in ID
id_rs2  in  5  rs2 index of instruction in ID
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_used  in  1  ID instruction reads rs2
ex_rs1  in  5  rs1 index of instruction in EX
ex_rs2  in  5  rs2 index of instruction in EX
ex_wR  in  5  destination of EX instruction
ex_rf_we  in  1  EX instruction writes RF
ex_is_load  in  1  EX instruction is a load
ex_branch_taken  in  1  branch/jump resolved taken in EX
mem_wR  in  5  destination in EX/MEM register
mem_rf_we  in  1  EX/MEM write enable
mem_req  in  1  MEM stage issuing data-memory access
mem_ack  in  1  data memory completes access this cycle
wb_wR  in  5  destination in MEM/WB register
wb_rf_we  in  1  MEM/WB write enable
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID
if_id_flush  out  1  bubble IF/ID
id_ex_stall  out  1  hold ID/EX
id_ex_flush  out  1  bubble ID/EX
ex_mem_stall  out  1  hold EX/MEM
mem_wb_flush  out  1  load bubble into MEM/WB (rf_we=0, have_inst=0)
fwd_a_sel  out  2  EX operand A source: 0 RF, 1 EX/MEM, 2 MEM/WB
fwd_b_sel  out  2  EX operand B source, same encoding
mem_timeout  out  1  sticky: a MEM_WAIT exceeded TIMEOUT
stall_cnt  out  CNT_W  cycles with pc_stall=1, saturating
flush_cnt  out  CNT_W  taken-branch flush events, saturating

Behaviour:
- Reset: FSM=RUN, wait counter=0, mem_timeout=0, stall_cnt=0, flush_cnt=0. Combinational outputs follow their equations with FSM=RUN.
- FSM states: RUN, MEM_WAIT.
  - RUN -> MEM_WAIT when mem_req=1 and mem_ack=0.
  - MEM_WAIT -> RUN on mem_ack=1.
  - mem_req=1 and mem_ack=1 in the same RUN cycle: zero-wait access, no stall.
- mem_busy = (RUN & mem_req & ~mem_ack) | (MEM_WAIT & ~mem_ack).
- mem_busy takes priority over all other conditions:
  - pc_stall, if_id_stall, id_ex_stall, ex_mem_stall = 1; mem_wb_flush = 1.
  - All other flushes = 0; a taken branch is deferred, since EX is frozen and re-presents it.
- Wait counter:
  - Cleared on entry to MEM_WAIT; increments each MEM_WAIT cycle.
  - When it reaches TIMEOUT, mem_timeout sets and stays 1 until rst. The FSM keeps waiting.
- Branch, when not mem_busy and ex_branch_taken=1:
  - if_id_flush = 1, id_ex_flush = 1, all stalls = 0.
  - flush_cnt increments once per cycle asserted.
- Load-use, when not mem_busy, no taken branch, and all of the following hold:
  - ex_is_load & ex_rf_we & ex_wR != 0;
  - (id_rs1_used & id_rs1 == ex_wR) | (id_rs2_used & id_rs2 == ex_wR).
  - Response: pc_stall = 1, if_id_stall = 1, id_ex_flush = 1, for exactly one cycle. The load then advances and clears the hazard.
- Branch + load-use in the same cycle: the branch wins; the ID instruction is squashed.
- Forwarding (combinational, independent of stalls):
  - Operand A: sel=1 if mem_rf_we & mem_wR != 0 & mem_wR == ex_rs1; else sel=2 if wb_rf_we & wb_wR != 0 & wb_wR == ex_rs1; else 0.
  - Operand B: same rule using ex_rs2.
  - x0 is never forwarded.
- Counters:
  - stall_cnt increments every clock with pc_stall=1.
  - Both counters saturate at 2^CNT_W-1.
- Stall/flush outputs are combinational from inputs and FSM state, with no registered latency.
- Reset asserted mid-MEM_WAIT returns to RUN immediately (asynchronous).

Test Plan:
1. Load x5 in EX with ex_is_load=1; ID reads rs2=5 -> exactly one cycle of pc_stall=1, if_id_stall=1, id_ex_flush=1; stall_cnt 0->1.
2. ex_branch_taken=1 together with the load-use of case 1 -> if_id_flush=1, id_ex_flush=1, pc_stall=0; flush_cnt=1.
3. mem_req=1; mem_ack rises 3 cycles later -> 3 cycles of all stalls plus mem_wb_flush=1, FSM back to RUN on the ack cycle; stall_cnt=3.
4. ex_rs1=ex_rs2=7, mem_wR=wb_wR=7, both write enables=1 -> fwd_a_sel=fwd_b_sel=1. Set mem_rf_we=0 -> both sels=2. Set mem_wR=wb_wR=0 with both write enables=1 -> both sels=0.
5. TIMEOUT=4, mem_ack held 0 -> mem_timeout rises after 4 MEM_WAIT cycles and stays 1 after ack. Only rst clears it.
6. Assert rst during MEM_WAIT with ex_branch_taken=1 -> all counters=0, mem_timeout=0, FSM=RUN. After rst deasserts: stalls=0, flush follows the branch.
